// File: rtl/dma_reg_responder.sv
// DMA register-bus responder: programming registers plus a word-countdown transfer engine.
// Define DMA_REG_ERR_EN to add ERROR_STATUS at 0x18 and the INTR err_status/err_mask bits.
module dma_reg_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h400,
    parameter int          CNT_W     = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        intr,
    output logic        busy
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    localparam logic [2:0] IDX_INTR   = 3'd0;
    localparam logic [2:0] IDX_CTRL   = 3'd1;
    localparam logic [2:0] IDX_IO     = 3'd2;
    localparam logic [2:0] IDX_MEM    = 3'd3;
    localparam logic [2:0] IDX_STATUS = 3'd4;
    localparam logic [2:0] IDX_TOTAL  = 3'd5;
    localparam logic [2:0] IDX_ERR    = 3'd6;

`ifdef DMA_REG_ERR_EN
    localparam logic [31:0] LAST_OFS = 32'h18;
`else
    localparam logic [31:0] LAST_OFS = 32'h14;
`endif

    state_t           r_state;
    logic             r_busy;
    logic             r_done_status;
    logic             r_done_mask;
    logic             r_done;
    logic             r_io_mem;
    logic [CNT_W-1:0] r_w_count;
    logic [CNT_W-1:0] r_rem;
    logic [31:0]      r_io_addr;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_xfer_total;
    logic [31:0]      r_rdata;

    logic [31:0]      w_offset;
    logic             w_mapped;
    logic [2:0]       w_idx;
    logic             w_wr_intr;
    logic             w_wr_ctrl;
    logic             w_wr_io;
    logic             w_wr_mem;
    logic [CNT_W-1:0] w_new_count;
    logic             w_start_req;
    logic             w_start_ok;
    logic             w_err_any;
    logic             w_err_intr;
    logic [31:0]      w_rdata;
    logic             w_unused;

    // Offsets below BASE_ADDR wrap to huge values and so decode as unmapped.
    assign w_offset    = {addr[31:2], 2'b00} - BASE_ADDR;
    assign w_mapped    = (w_offset <= LAST_OFS);
    assign w_idx       = w_offset[4:2];

    assign w_wr_intr   = wr_en & w_mapped & (w_idx == IDX_INTR);
    assign w_wr_ctrl   = wr_en & w_mapped & (w_idx == IDX_CTRL);
    assign w_wr_io     = wr_en & w_mapped & (w_idx == IDX_IO);
    assign w_wr_mem    = wr_en & w_mapped & (w_idx == IDX_MEM);

    assign w_new_count = wdata[CNT_W:1];
    assign w_start_req = w_wr_ctrl & wdata[0];
    assign w_start_ok  = w_start_req & (r_state == S_IDLE) & (w_new_count != '0);

    assign w_unused    = &{1'b0, addr[1:0], wdata[31:17]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_rem         <= '0;
            r_xfer_total  <= '0;
            r_done        <= 1'b0;
            r_done_status <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_state <= S_BUSY;
                        r_busy  <= 1'b1;
                        r_rem   <= w_new_count;
                        r_done  <= 1'b0;
                    end
                end
                S_BUSY: begin
                    r_rem        <= r_rem - CNT_W'(1);
                    r_xfer_total <= r_xfer_total + 32'd1;
                    if (r_rem == CNT_W'(1)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            // Completion beats a same-cycle W1C of done_status.
            if (r_state == S_DONE) begin
                r_done_status <= 1'b1;
            end else if (w_wr_intr && wdata[0]) begin
                r_done_status <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done_mask <= 1'b1;
            r_w_count   <= '0;
            r_io_mem    <= 1'b0;
            r_io_addr   <= '0;
            r_mem_addr  <= '0;
        end else begin
            if (w_wr_intr) begin
                r_done_mask <= wdata[16];
            end
            if (w_wr_ctrl) begin
                r_w_count <= w_new_count;
                r_io_mem  <= wdata[16];
            end
            if (w_wr_io) begin
                r_io_addr <= wdata;
            end
            if (w_wr_mem) begin
                r_mem_addr <= wdata;
            end
        end
    end

`ifdef DMA_REG_ERR_EN
    logic [2:0] r_err;
    logic       r_err_status;
    logic       r_err_mask;
    logic       w_wr_err;
    logic [2:0] w_err_set;
    logic [2:0] w_err_clr;

    assign w_wr_err  = wr_en & w_mapped & (w_idx == IDX_ERR);
    assign w_err_set = {w_start_req & (r_state == S_IDLE) & (w_new_count == '0),
                        w_start_req & (r_state != S_IDLE),
                        (wr_en | rd_en) & ~w_mapped};
    assign w_err_clr = w_wr_err ? wdata[2:0] : 3'b000;

    // New error events win over a same-cycle W1C, matching done_status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err        <= '0;
            r_err_status <= 1'b0;
            r_err_mask   <= 1'b0;
        end else begin
            r_err        <= (r_err & ~w_err_clr) | w_err_set;
            r_err_status <= (|w_err_set) | (r_err_status & ~(w_wr_intr & wdata[1]));
            if (w_wr_intr) begin
                r_err_mask <= wdata[17];
            end
        end
    end

    assign w_err_any  = |r_err;
    assign w_err_intr = r_err_status & r_err_mask;
`else
    assign w_err_any  = 1'b0;
    assign w_err_intr = 1'b0;
`endif

    always_comb begin
        w_rdata = '0;
        case (w_idx)
            IDX_INTR: begin
                w_rdata[0]  = r_done_status;
                w_rdata[16] = r_done_mask;
`ifdef DMA_REG_ERR_EN
                w_rdata[1]  = r_err_status;
                w_rdata[17] = r_err_mask;
`endif
            end
            IDX_CTRL: begin
                w_rdata[CNT_W:1] = r_w_count;
                w_rdata[16]      = r_io_mem;
            end
            IDX_IO:     w_rdata = r_io_addr;
            IDX_MEM:    w_rdata = r_mem_addr;
            IDX_STATUS: begin
                w_rdata[0]          = r_busy;
                w_rdata[1]          = r_done;
                w_rdata[2]          = w_err_any;
                w_rdata[16 +: CNT_W] = r_rem;
            end
            IDX_TOTAL:  w_rdata = r_xfer_total;
`ifdef DMA_REG_ERR_EN
            IDX_ERR:    w_rdata[2:0] = r_err;
`endif
            default:    w_rdata = '0;
        endcase
        if (!w_mapped) begin
            w_rdata = '0;
        end
    end

    // Read data is captured from pre-edge register values, so a same-cycle write is not seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (rd_en) begin
            r_rdata <= w_rdata;
        end
    end

    assign rdata = r_rdata;
    assign busy  = r_busy;
    assign intr  = (r_done_status & r_done_mask) | w_err_intr;

endmodule

// File: tb/tb_dma_reg_responder.sv
// Scoreboard bench for dma_reg_responder: a timestamp-based reference model predicts
// every read and the busy/intr levels after each edge; a monitor pops and compares.
module tb_dma_reg_responder;
    localparam logic [31:0] BASE = 32'h400;
`ifdef DMA_REG_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        intr;
    logic        busy;

    always #5 clk = ~clk;

    dma_reg_responder #(.BASE_ADDR(BASE), .CNT_W(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (wr_en),
        .rd_en (rd_en),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .intr  (intr),
        .busy  (busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] exp_rd_q[$];
    logic [1:0]  exp_st_q[$];

    // Reference model. Edge e is the clock edge about to happen; the transfer is
    // described by its start edge x_k0 and length x_n rather than by a state machine.
    int          e = 0;
    logic [31:0] m_io, m_mem, m_tot_base;
    logic [14:0] m_wc;
    logic        m_iomem, m_dmask, m_dstat, m_done;
    bit          have_x;
    int          x_k0, x_n;
    logic [2:0]  m_err;
    logic        m_eint, m_emask;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, expv);
        end
    endtask

    function automatic void m_reset();
        m_io = '0; m_mem = '0; m_tot_base = '0; m_wc = '0;
        m_iomem = 1'b0; m_dmask = 1'b1; m_dstat = 1'b0; m_done = 1'b0;
        have_x = 1'b0; x_k0 = 0; x_n = 0;
        m_err = '0; m_eint = 1'b0; m_emask = 1'b0;
    endfunction

    function automatic bit in_xfer(int t);
        return have_x && (t >= x_k0) && (t <= x_k0 + x_n);
    endfunction

    function automatic bit m_busy(int t);
        return have_x && (t >= x_k0) && (t < x_k0 + x_n);
    endfunction

    function automatic int m_rem(int t);
        return in_xfer(t) ? (x_n - (t - x_k0)) : 0;
    endfunction

    function automatic logic [31:0] m_total(int t);
        int done_words;
        if (!have_x || t < x_k0) return m_tot_base;
        done_words = (t - x_k0 > x_n) ? x_n : (t - x_k0);
        return m_tot_base + 32'(done_words);
    endfunction

    function automatic logic [31:0] m_off(logic [31:0] a);
        return {a[31:2], 2'b00} - BASE;
    endfunction

    function automatic bit m_mapped(logic [31:0] off);
        return off <= (ERR_EN ? 32'h18 : 32'h14);
    endfunction

    function automatic logic m_intr();
        return (m_dstat & m_dmask) | (ERR_EN & m_eint & m_emask);
    endfunction

    function automatic logic [31:0] m_read(logic [31:0] a);
        logic [31:0] off;
        logic [2:0]  er;
        logic        ei, em;
        int          t;
        t   = e - 1;
        off = m_off(a);
        er  = ERR_EN ? m_err : 3'b000;
        ei  = ERR_EN & m_eint;
        em  = ERR_EN & m_emask;
        if (!m_mapped(off)) return 32'h0;
        case (off)
            32'h00:  return {14'd0, em, m_dmask, 14'd0, ei, m_dstat};
            32'h04:  return {15'd0, m_iomem, m_wc, 1'b0};
            32'h08:  return m_io;
            32'h0C:  return m_mem;
            32'h10:  return {16'(m_rem(t)), 13'd0, |er, m_done, m_busy(t)};
            32'h14:  return m_total(t);
            32'h18:  return {29'd0, er};
            default: return 32'h0;
        endcase
    endfunction

    function automatic void m_apply(bit w, bit r, logic [31:0] a, logic [31:0] d);
        logic [31:0] off;
        logic [2:0]  eset;
        off  = m_off(a);
        eset = 3'b000;
        if (!m_mapped(off) && (w || r)) eset[0] = 1'b1;
        if (w && m_mapped(off)) begin
            case (off)
                32'h00: begin
                    if (d[0]) m_dstat = 1'b0;
                    if (d[1]) m_eint = 1'b0;
                    m_dmask = d[16];
                    m_emask = d[17];
                end
                32'h04: begin
                    m_wc    = d[15:1];
                    m_iomem = d[16];
                    if (d[0]) begin
                        if (in_xfer(e - 1)) begin
                            eset[1] = 1'b1;
                        end else if (d[15:1] == 15'd0) begin
                            eset[2] = 1'b1;
                        end else begin
                            if (have_x) m_tot_base = m_tot_base + 32'(x_n);
                            have_x = 1'b1;
                            x_k0   = e;
                            x_n    = int'(d[15:1]);
                            m_done = 1'b0;
                        end
                    end
                end
                32'h08: m_io  = d;
                32'h0C: m_mem = d;
                32'h18: m_err = m_err & ~d[2:0];
                default: ;
            endcase
        end
        if (have_x && e == x_k0 + x_n + 1) begin
            m_dstat = 1'b1;
            m_done  = 1'b1;
        end
        m_err = m_err | eset;
        if (|eset) m_eint = 1'b1;
    endfunction

    task automatic step(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
        wr_en = w;
        rd_en = r;
        addr  = a;
        wdata = d;
        if (r) exp_rd_q.push_back(m_read(a));
        m_apply(w, r, a, d);
        exp_st_q.push_back({m_busy(e), m_intr()});
        e++;
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        step(1'b1, 1'b0, BASE + off, d);
    endtask

    task automatic rd(input logic [31:0] off);
        step(1'b0, 1'b1, BASE + off, 32'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, BASE, 32'h0);
    endtask

    // Monitor: one status entry per stimulus edge, plus read data when a read was issued.
    initial begin
        logic       rs;
        logic [1:0] st;
        forever begin
            @(posedge clk);
            rs = rd_en;
            #1;
            if (exp_st_q.size() > 0) begin
                st = exp_st_q.pop_front();
                check("busy", 32'(busy), 32'(st[1]));
                check("intr", 32'(intr), 32'(st[0]));
                if (rs && exp_rd_q.size() > 0) check("rdata", rdata, exp_rd_q.pop_front());
            end
        end
    end

    initial begin
        m_reset();
        @(negedge clk);
        check("reset_rdata", rdata, 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_intr", 32'(intr), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) rd(32'(4 * i));

        wr(32'h08, 32'hA5A5_5A5A);
        rd(32'h08);
        wr(32'h0C, 32'h1357_9BDF);
        rd(32'h0C);

        wr(32'h04, 32'h0000_0009);
        for (int i = 0; i < 7; i++) rd(32'h10);
        rd(32'h14);
        rd(32'h00);

        wr(32'h00, 32'h0001_0001);
        rd(32'h00);
        wr(32'h00, 32'h0000_0000);
        wr(32'h04, 32'h0000_0005);
        for (int i = 0; i < 5; i++) rd(32'h10);
        rd(32'h00);
        wr(32'h00, 32'h0001_0000);
        wr(32'h00, 32'h0001_0001);

        wr(32'h04, 32'h0000_0011);
        rd(32'h10);
        wr(32'h04, 32'h0000_0003);
        for (int i = 0; i < 10; i++) rd(32'h10);
        rd(32'h18);
        rd(32'h14);
        rd(32'h04);

        wr(32'h04, 32'h0001_0001);
        rd(32'h10);
        rd(32'h04);

        step(1'b1, 1'b1, BASE + 32'h08, 32'h1234_5678);
        rd(32'h08);
        step(1'b1, 1'b1, BASE + 32'h40, 32'hFFFF_FFFF);
        step(1'b0, 1'b1, BASE - 32'h4, 32'h0);
        step(1'b1, 1'b0, BASE + 32'h18, 32'hFFFF_FFFF);
        rd(32'h18);
        step(1'b0, 1'b1, BASE + 32'h0B, 32'h0);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            logic [31:0] d;
            int          k;
            k = int'($urandom_range(0, 10));
            if (k <= 7)       a = BASE + 32'(4 * k);
            else if (k == 8)  a = BASE + 32'h100;
            else if (k == 9)  a = BASE - 32'h4;
            else              a = $urandom;
            a[1:0] = 2'($urandom_range(0, 3));
            d = $urandom;
            if (k == 1) d[15:1] = 15'($urandom_range(0, 10));
            step($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, a, d);
        end

        idle(15);
        wr(32'h00, 32'h0001_0003);
        wr(32'h04, 32'h0000_000D);
        rd(32'h10);
        rd(32'h10);
        rd(32'h10);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy), 32'h0);
        check("async_rst_rdata", rdata, 32'h0);
        check("async_rst_intr", 32'(intr), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        rd(32'h10);
        rd(32'h14);
        rd(32'h00);
        for (int i = 0; i < 12; i++) rd(32'h10);

        @(negedge clk);
        check("scoreboard_drain", 32'(exp_st_q.size() + exp_rd_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
